// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port memory between the instruction-fetch port (read only)
// and the data port (read/write). One requester is granted per cycle; the data
// port wins by default, but a fetch that has been denied MAX_WAIT cycles in a
// row is granted ahead of the data port. The memory returns read data one cycle
// after the address is presented. A registered owner tag steers that data back
// to whichever port issued the read.
//
// Ports
//   CLK, RST         clock (rising edge), synchronous active-high reset
//   I_REQ/I_ADDR     fetch request and address
//   I_GNT            fetch accepted this cycle (combinational)
//   I_VALID/I_RDATA  fetch read response, one cycle after I_GNT
//   D_REQ/D_WE       data request and direction (1 = write)
//   D_ADDR/D_WDATA   data address and write data
//   D_GNT            data access accepted this cycle (combinational)
//   D_VALID/D_RDATA  data read response, one cycle after a read grant
//   M_ADDR/M_WDATA   memory address and write data
//   M_WRITE          memory write strobe
//   M_RDATA          memory read data (one cycle latency)
//   CONFLICT_CNT     saturating count of cycles where both ports requested
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_VALID,
    output logic [DATA_W-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_VALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic              M_WRITE,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic [15:0]       CONFLICT_CNT
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

    // Which port the read data arriving this cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t        owner_reg,    owner_next;
    logic [SW-1:0] starve_reg,   starve_next;
    logic [15:0]   conflict_reg, conflict_next;

    logic i_gnt;
    logic d_gnt;

    // Arbitration and memory drive. Nothing is granted while reset is held so
    // that a read issued in a reset cycle can never produce a response.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        M_ADDR  = '0;
        M_WDATA = '0;
        M_WRITE = 1'b0;
        if (!RST) begin
            if (I_REQ && (starve_reg == STARVE_MAX)) begin
                i_gnt = 1'b1;
            end else if (D_REQ) begin
                d_gnt = 1'b1;
            end else if (I_REQ) begin
                i_gnt = 1'b1;
            end
        end
        if (i_gnt) begin
            M_ADDR = I_ADDR;
        end else if (d_gnt) begin
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
            M_WRITE = D_WE;
        end
    end

    // Next-state logic for owner tag, starvation and conflict counters.
    always_comb begin
        owner_next    = OWN_NONE;
        starve_next   = '0;
        conflict_next = conflict_reg;

        if (i_gnt) begin
            owner_next = OWN_I;
        end else if (d_gnt && !D_WE) begin
            owner_next = OWN_D;
        end

        // Counter clears whenever the fetch is granted or not requesting.
        if (I_REQ && !i_gnt) begin
            starve_next = (starve_reg == STARVE_MAX) ? starve_reg : starve_reg + 1'b1;
        end

        if (I_REQ && D_REQ && (conflict_reg != 16'hFFFF)) begin
            conflict_next = conflict_reg + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_reg    <= OWN_NONE;
            starve_reg   <= '0;
            conflict_reg <= '0;
        end else begin
            owner_reg    <= owner_next;
            starve_reg   <= starve_next;
            conflict_reg <= conflict_next;
        end
    end

    assign I_GNT        = i_gnt;
    assign D_GNT        = d_gnt;
    assign I_VALID      = (owner_reg == OWN_I);
    assign D_VALID      = (owner_reg == OWN_D);
    assign I_RDATA      = (owner_reg == OWN_I) ? M_RDATA : '0;
    assign D_RDATA      = (owner_reg == OWN_D) ? M_RDATA : '0;
    assign CONFLICT_CNT = conflict_reg;

endmodule
